// File: rtl/pc_fetch_unit_if.sv
// Fetch-stage bundle: redirect controls from the datapath and PC/ROM address back out.
// The master side drives the redirect inputs; the fetch unit is the slave.
interface pc_fetch_unit_if;
    logic        stall;
    logic        branch_taken;
    logic [15:0] branch_imm;
    logic        jump;
    logic [25:0] jump_target;
    logic        jr;
    logic [31:0] jr_addr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] Addr;
    logic        fetch_err;
    logic [31:0] fetch_cnt;

    modport master (
        output stall, branch_taken, branch_imm, jump, jump_target, jr, jr_addr,
        input  pc, pc_plus4, Addr, fetch_err, fetch_cnt
    );

    modport slave (
        input  stall, branch_taken, branch_imm, jump, jump_target, jr, jr_addr,
        output pc, pc_plus4, Addr, fetch_err, fetch_cnt
    );
endinterface

// File: rtl/pc_fetch_unit.sv
// PC register and next-PC select (stall > jr > jump > branch > sequential); one-cycle redirect latency.
// Illegal targets freeze the unit in HALT until reset; stall holds PC, counter and error flag.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_WORDS = 1024
) (
    input  logic           clk,
    input  logic           rst_n,
    pc_fetch_unit_if.slave fi
);
    localparam logic [31:0] IMEM_WORDS_W = 32'(IMEM_WORDS);

    typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:0] cnt_q;

    logic [31:0] pc_plus4;
    logic [31:0] br_off;
    logic [31:0] target_d;
    logic [29:0] off_words;
    logic        legal_d;

    always_comb begin
        pc_plus4 = pc_q + 32'd4;
        br_off   = {{14{fi.branch_imm[15]}}, fi.branch_imm, 2'b00};
        target_d = pc_plus4;
        if (fi.jr) begin
            target_d = fi.jr_addr;
        end else if (fi.jump) begin
            target_d = {pc_plus4[31:28], fi.jump_target, 2'b00};
        end else if (fi.branch_taken) begin
            target_d = pc_plus4 + br_off;
        end
    end

    // RESET_PC is word-aligned, so the word offset can be taken on [31:2] directly;
    // misaligned targets are rejected by the low-bit test regardless.
    assign off_words = target_d[31:2] - RESET_PC[31:2];
    assign legal_d   = (target_d[1:0] == 2'b00) && ({2'b00, off_words} < IMEM_WORDS_W);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
            cnt_q   <= 32'd0;
        end else if (state_q == RUN && !fi.stall) begin
            if (legal_d) begin
                pc_q  <= target_d;
                cnt_q <= cnt_q + 32'd1;
            end else begin
                state_q <= HALT;
            end
        end
    end

    assign fi.pc        = pc_q;
    assign fi.pc_plus4  = pc_plus4;
    assign fi.Addr      = {2'b00, pc_q[31:2]};
    assign fi.fetch_err = (state_q == HALT);
    assign fi.fetch_cnt = cnt_q;
endmodule
